// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the mux select through enabled channels, samples each after a settle time, hands out a packed frame
module mux_scan_sequencer #(
  parameter int NUM_CH = 31,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic [SEL_W-1:0]         sel,
  input  logic [DATA_W-1:0]        mux_out,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_VALID} state_t;
  localparam logic [SEL_W-1:0] PARK = '1;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam state_t LOAD_ST = SETTLE == 0 ? ST_SAMPLE : ST_SETTLE;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, first_ch, next_ch;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0] frame_q, frame_d;
  logic busy_q, busy_d, valid_q, valid_d, has_next;
  always_comb begin
    first_ch = '0;
    next_ch = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = SEL_W'(i);
      if (mask_q[i] && SEL_W'(i) > sel_q) begin
        next_ch = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: if (start) begin
        frame_d = '0;
        mask_d = ch_mask;
        if (|ch_mask) begin
          sel_d = first_ch;
          cnt_d = SETTLE_CNT;
          state_d = LOAD_ST;
        end else state_d = ST_VALID;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        frame_d[DATA_W*sel_q +: DATA_W] = mux_out;
        sel_d = has_next ? next_ch : PARK;
        cnt_d = SETTLE_CNT;
        state_d = has_next ? LOAD_ST : ST_VALID;
      end
      default: if (frame_ready) state_d = ST_IDLE;
    endcase
    busy_d = state_d != ST_IDLE;
    valid_d = state_d == ST_VALID;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q <= PARK;
      mask_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign sel = sel_q;
  assign busy = busy_q;
  assign frame = frame_q;
  assign frame_valid = valid_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized self-checking bench for mux_scan_sequencer (SETTLE=1 and SETTLE=0 builds)
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic start0, start1, ready0, ready1;
  logic [30:0] mask0, mask1;
  logic [1:0] mux0, mux1;
  logic [4:0] sel0, sel1;
  logic busy0, busy1, fv0, fv1;
  logic [61:0] frame0, frame1;
  logic [61:0] last_exp;
  logic [1:0] lut [32];
  logic [1:0] tog = 2'd0;
  int mode = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) tog <= tog + 2'd1;
  always_comb begin
    mux0 = mode == 0 ? sel0[1:0] : mode == 1 ? 2'd3 : mode == 2 ? lut[sel0] : tog;
    mux1 = mode == 0 ? sel1[1:0] : mode == 1 ? 2'd3 : mode == 2 ? lut[sel1] : tog;
  end
  mux_scan_sequencer #(.SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .ch_mask(mask0), .sel(sel0), .mux_out(mux0),
    .busy(busy0), .frame(frame0), .frame_valid(fv0), .frame_ready(ready0)
  );
  mux_scan_sequencer #(.SETTLE(0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .ch_mask(mask1), .sel(sel1), .mux_out(mux1),
    .busy(busy1), .frame(frame1), .frame_valid(fv1), .frame_ready(ready1)
  );
  function automatic logic [4:0] g_sel(input int d);
    return d != 0 ? sel1 : sel0;
  endfunction
  function automatic logic g_busy(input int d);
    return d != 0 ? busy1 : busy0;
  endfunction
  function automatic logic g_fv(input int d);
    return d != 0 ? fv1 : fv0;
  endfunction
  function automatic logic [61:0] g_frame(input int d);
    return d != 0 ? frame1 : frame0;
  endfunction
  function automatic logic [1:0] model_val(input int i);
    return mode == 0 ? 2'(i % 4) : mode == 1 ? 2'd3 : lut[i];
  endfunction
  task automatic set_start(input int d, input logic v, input logic [30:0] m);
    if (d != 0) begin
      start1 = v;
      mask1 = m;
    end else begin
      start0 = v;
      mask0 = m;
    end
  endtask
  task automatic set_ready(input int d, input logic v);
    if (d != 0) ready1 = v;
    else ready0 = v;
  endtask
  task automatic randomize_lut();
    for (int i = 0; i < 32; i++) lut[i] = 2'($urandom);
  endtask
  task automatic run_scan(input int d, input logic [30:0] m);
    int s, n, k;
    int chans[$];
    logic [61:0] exp_f;
    logic [4:0] es;
    s = d != 0 ? 0 : 1;
    exp_f = '0;
    for (int i = 0; i < 31; i++)
      if (m[i]) begin
        chans.push_back(i);
        exp_f[2*i +: 2] = model_val(i);
      end
    n = chans.size();
    set_start(d, 1'b1, m);
    @(posedge clk);
    @(negedge clk);
    set_start(d, 1'b0, 31'($urandom));
    k = 0;
    while (!g_fv(d) && k < 200) begin
      if (k < n * (s + 1)) begin
        es = 5'(chans[k / (s + 1)]);
        tests++;
        if (g_sel(d) !== es || g_busy(d) !== 1'b1) begin
          fails++;
          $display("FAIL scan_sel dut%0d cycle %0d: got sel=%0d busy=%b, expected sel=%0d busy=1", d, k, g_sel(d), g_busy(d), es);
        end
      end
      k++;
      @(negedge clk);
    end
    tests++;
    if (k !== n * (s + 1)) begin
      fails++;
      $display("FAIL latency dut%0d mask=%h: got %0d cycles, expected %0d", d, m, k, n * (s + 1));
    end
    tests++;
    if (g_frame(d) !== exp_f) begin
      fails++;
      $display("FAIL frame dut%0d mask=%h: got %h, expected %h", d, m, g_frame(d), exp_f);
    end
    tests++;
    if (g_sel(d) !== 5'd31 || g_busy(d) !== 1'b1 || g_fv(d) !== 1'b1) begin
      fails++;
      $display("FAIL valid_state dut%0d: got sel=%0d busy=%b fv=%b, expected 31/1/1", d, g_sel(d), g_busy(d), g_fv(d));
    end
    last_exp = exp_f;
  endtask
  task automatic handshake(input int d);
    set_ready(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ready(d, 1'b0);
    tests++;
    if (g_fv(d) !== 1'b0 || g_busy(d) !== 1'b0 || g_sel(d) !== 5'd31 || g_frame(d) !== last_exp) begin
      fails++;
      $display("FAIL handshake dut%0d: got fv=%b busy=%b sel=%0d frame=%h, expected 0/0/31 frame=%h", d, g_fv(d), g_busy(d), g_sel(d), g_frame(d), last_exp);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (g_sel(d) !== 5'd31 || g_frame(d) !== 62'd0 || g_fv(d) !== 1'b0 || g_busy(d) !== 1'b0) begin
        fails++;
        $display("FAIL reset dut%0d: got sel=%0d frame=%h fv=%b busy=%b, expected 31/0/0/0", d, g_sel(d), g_frame(d), g_fv(d), g_busy(d));
      end
    end
  endtask
  task automatic test_full_scan();
    mode = 0;
    run_scan(0, '1);
    tests++;
    if (frame0[1:0] !== 2'd0 || frame0[25:24] !== 2'd0 || frame0[61:60] !== 2'd2) begin
      fails++;
      $display("FAIL full_fields: got ch0=%0d ch12=%0d ch30=%0d, expected 0/0/2", frame0[1:0], frame0[25:24], frame0[61:60]);
    end
    handshake(0);
  endtask
  task automatic test_sparse();
    mode = 1;
    run_scan(0, 31'h4000_1000);
    tests++;
    if (frame0 !== {2'd3, 34'd0, 2'd3, 24'd0}) begin
      fails++;
      $display("FAIL sparse_frame: got %h, expected ch12=ch30=3 only", frame0);
    end
    handshake(0);
  endtask
  task automatic test_zero_mask();
    mode = 2;
    randomize_lut();
    run_scan(0, '0);
    handshake(0);
  endtask
  task automatic test_random();
    mode = 2;
    for (int r = 0; r < 6; r++) begin
      randomize_lut();
      run_scan(0, 31'($urandom & $urandom));
      handshake(0);
    end
  endtask
  task automatic test_backpressure();
    mode = 2;
    randomize_lut();
    run_scan(0, 31'($urandom) | 31'd1);
    mode = 3;
    for (int c = 0; c < 20; c++) begin
      start0 = (c % 3) == 0;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (fv0 !== 1'b1 || busy0 !== 1'b1 || frame0 !== last_exp) begin
        fails++;
        $display("FAIL backpressure cycle %0d: got fv=%b busy=%b frame=%h, expected 1/1 frame=%h", c, fv0, busy0, frame0, last_exp);
      end
    end
    start0 = 1'b1;
    ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    ready0 = 1'b0;
    tests++;
    if (fv0 !== 1'b0 || busy0 !== 1'b0 || frame0 !== last_exp) begin
      fails++;
      $display("FAIL bp_release: got fv=%b busy=%b frame=%h, expected 0/0 frame=%h", fv0, busy0, frame0, last_exp);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (busy0 !== 1'b0 || sel0 !== 5'd31) begin
        fails++;
        $display("FAIL no_second_scan cycle %0d: got busy=%b sel=%0d, expected 0/31", c, busy0, sel0);
      end
    end
    mode = 2;
  endtask
  task automatic test_reset_mid();
    int k;
    mode = 0;
    set_start(0, 1'b1, '1);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (sel0 !== 5'd15 && k < 100) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k >= 100) begin
      fails++;
      $display("FAIL reach_sel15: got sel=%0d after %0d cycles, expected 15", sel0, k);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (sel0 !== 5'd31 || frame0 !== 62'd0 || busy0 !== 1'b0 || fv0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got sel=%0d frame=%h busy=%b fv=%b, expected 31/0/0/0", sel0, frame0, busy0, fv0);
    end
    run_scan(0, '1);
    handshake(0);
  endtask
  task automatic test_settle0();
    mode = 0;
    run_scan(1, '1);
    handshake(1);
    mode = 2;
    for (int r = 0; r < 3; r++) begin
      randomize_lut();
      run_scan(1, 31'($urandom));
      handshake(1);
    end
  endtask
  task automatic test_back_to_back();
    mode = 2;
    randomize_lut();
    run_scan(0, 31'($urandom));
    handshake(0);
    run_scan(0, 31'($urandom));
    handshake(0);
  endtask
  initial begin
    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    ready0 = 1'b0;
    ready1 = 1'b0;
    mask0 = '0;
    mask1 = '0;
    last_exp = '0;
    for (int i = 0; i < 32; i++) lut[i] = 2'd0;
    @(negedge clk);
    test_reset();
    test_full_scan();
    test_sparse();
    test_zero_mask();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_settle0();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
